// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and the future UART receiver.
//   Contents:
//     uart_state_e          - 3-bit frame-sequencer state encoding
//     UART_CLKS_PER_BIT_DEF - default bit period (100 MHz clock, 115200 baud)
//     PARITY_EVEN/ODD       - parity-mode constants
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_e;

    localparam int unsigned UART_CLKS_PER_BIT_DEF = 32'd868;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period timer. Counts 0 .. clks_per_bit-1 and raises bit_tick for one
//   cycle while the count sits at clks_per_bit-1. A synchronous clear parks
//   the count at 0 so the following bit period is exactly full width.
//   Ports:
//     clk      in   system clock
//     rst_n    in   synchronous active-low reset
//     clear    in   synchronous counter clear
//     bit_tick out  registered one-cycle pulse at the end of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned clks_per_bit = UART_CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned   CNT_W   = $clog2(clks_per_bit);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(clks_per_bit - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count and next tick; the tick is registered so it lines up with
    // the cycle in which the count reads CNT_MAX.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = (cnt_d == CNT_MAX);
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign bit_tick = tick_q;

endmodule : uart_baud_gen

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter that is the sole reader of a synchronous FIFO. Pops one
//   byte at a time and serialises it LSB first as start / data / [parity] /
//   stop(s). Back-to-back frames are separated by exactly two idle-high
//   cycles (REQ + LOAD).
//   Ports:
//     clk      in   system clock, rising edge
//     rst_n    in   synchronous active-low reset
//     f_empty  in   FIFO empty flag
//     rd_data  in   FIFO read data, valid the cycle after rd_en
//     rd_en    out  one-cycle FIFO pop request (registered)
//     tx       out  serial line, idles high (registered)
//     tx_busy  out  high whenever the sequencer is not idle (registered)
//     tx_done  out  one-cycle pulse after the last stop bit (registered)
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned data_width   = 32'd8,
    parameter int unsigned clks_per_bit = UART_CLKS_PER_BIT_DEF,
    parameter int unsigned parity_en    = 32'd0,
    parameter int unsigned parity_odd   = 32'd0,
    parameter int unsigned stop_bits    = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_empty,
    input  logic [data_width-1:0] rd_data,
    output logic                  rd_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned      BIT_W     = $clog2(data_width) + 32'd1;
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(data_width - 32'd1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(stop_bits - 32'd1);
    localparam logic             PAR_EN    = (parity_en != 32'd0);
    localparam logic             PAR_MODE  = (parity_odd != 32'd0) ? PARITY_ODD : PARITY_EVEN;

    // Parity of a payload word; odd = 1 inverts the even-parity result.
    function automatic logic frame_parity(input logic [data_width-1:0] data,
                                          input logic odd);
        return (^data) ^ odd;
    endfunction

    uart_state_e           state_q,   state_d;
    logic [data_width-1:0] shift_q,   shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  parity_q,  parity_d;
    logic                  tx_q,      tx_d;
    logic                  rd_en_q,   rd_en_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  baud_clear_s;
    logic                  bit_tick_s;

    // Hold the bit timer at zero until the frame starts, so the start bit
    // begins a fresh, full-width period.
    assign baud_clear_s = (state_q == ST_IDLE) || (state_q == ST_REQ) ||
                          (state_q == ST_LOAD);

    uart_baud_gen #(
        .clks_per_bit (clks_per_bit)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear_s),
        .bit_tick (bit_tick_s)
    );

    // Frame sequencer: next state plus next value of every registered output.
    // tx_d is the level the line takes in the *next* state, so tx changes
    // exactly on the bit boundary.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!f_empty) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                tx_d    = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // rd_data is only non-zero in this cycle, so capture it now.
                shift_d   = rd_data;
                parity_d  = frame_parity(rd_data, PAR_MODE);
                bit_cnt_d = '0;
                tx_d      = 1'b0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_tick_s) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PAR_EN) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_d[0];
                        state_d   = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_tick_s) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        // Last stop bit done: the empty flag decides between
                        // back-to-back and idle.
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        if (!f_empty) begin
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = ST_STOP;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                tx_d      = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
        rd_en_d = (state_d == ST_REQ);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Three transmitters at 4 clocks per bit:
//     u_dut0 : 8N1          fed by a queue-based FIFO model
//     u_dut1 : 8E2          fed by a one-entry slot model
//     u_dut2 : 8O1          fed by a one-entry slot model
//   Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       has_par;
        logic       par;
        int         nstop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       f_empty0 = 1'b1, f_empty1 = 1'b1, f_empty2 = 1'b1;
    logic [7:0] rd_data0 = 8'h00, rd_data1 = 8'h00, rd_data2 = 8'h00;
    logic       rd_en0, rd_en1, rd_en2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    logic [7:0] q0[$];
    logic [7:0] slot1 = 8'h00, slot2 = 8'h00;

    int total = 0;
    int bad   = 0;
    int done_cnt0 = 0, rden_cnt0 = 0, underflow_cnt = 0;

    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_tx_fifo #(.data_width(8), .clks_per_bit(CPB), .parity_en(0),
                   .parity_odd(0), .stop_bits(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .f_empty(f_empty0), .rd_data(rd_data0),
        .rd_en(rd_en0), .tx(tx0), .tx_busy(busy0), .tx_done(done0));

    uart_tx_fifo #(.data_width(8), .clks_per_bit(CPB), .parity_en(1),
                   .parity_odd(0), .stop_bits(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .f_empty(f_empty1), .rd_data(rd_data1),
        .rd_en(rd_en1), .tx(tx1), .tx_busy(busy1), .tx_done(done1));

    uart_tx_fifo #(.data_width(8), .clks_per_bit(CPB), .parity_en(1),
                   .parity_odd(1), .stop_bits(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .f_empty(f_empty2), .rd_data(rd_data2),
        .rd_en(rd_en2), .tx(tx2), .tx_busy(busy2), .tx_done(done2));

    // Queue FIFO model for instance 0: registered read data, zero otherwise.
    always @(posedge clk) begin
        if (rd_en0) begin
            if (q0.size() == 0) begin
                underflow_cnt <= underflow_cnt + 1;
                rd_data0 <= 8'h00;
            end else begin
                rd_data0 <= q0.pop_front();
            end
        end else begin
            rd_data0 <= 8'h00;
        end
        f_empty0 <= (q0.size() == 0);
    end

    // One-entry source models for the parity instances.
    always @(posedge clk) begin
        if (rd_en1) begin
            rd_data1 <= slot1;
            f_empty1 <= 1'b1;
        end else begin
            rd_data1 <= 8'h00;
        end
        if (rd_en2) begin
            rd_data2 <= slot2;
            f_empty2 <= 1'b1;
        end else begin
            rd_data2 <= 8'h00;
        end
    end

    // Event counters for instance 0.
    always @(posedge clk) begin
        if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;
        if (rd_en0 === 1'b1) rden_cnt0 <= rden_cnt0 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int i);
        case (i)
            0: return tx0;
            1: return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int i);
        case (i)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int i);
        case (i)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    task automatic push(input int i, input logic [7:0] b);
        case (i)
            0: begin q0.push_back(b); f_empty0 = 1'b0; end
            1: begin slot1 = b; f_empty1 = 1'b0; end
            default: begin slot2 = b; f_empty2 = 1'b0; end
        endcase
    endtask

    // Checks one whole frame. With at_start = 1 the current sample is already
    // the first start-bit cycle; otherwise wait (bounded) for the line to fall.
    // Returns at the sample after the last stop cycle, where tx_done must be 1.
    task automatic expect_frame(input int i, input logic [7:0] b, input logic has_par,
                                input logic par, input int nstop, input bit at_start,
                                input string tag);
        logic exp_bits [0:11];
        int   n;
        int   w;
        int   errs;
        n = 0;
        exp_bits[n] = 1'b0; n++;
        for (int k = 0; k < 8; k++) begin exp_bits[n] = b[k]; n++; end
        if (has_par) begin exp_bits[n] = par; n++; end
        for (int s = 0; s < nstop; s++) begin exp_bits[n] = 1'b1; n++; end
        if (!at_start) begin
            w = 0;
            @(negedge clk);
            while (get_tx(i) !== 1'b0 && w < 300) begin
                @(negedge clk);
                w++;
            end
        end
        check($sformatf("%s start seen", tag), get_tx(i), 0);
        if (get_tx(i) !== 1'b0) return;
        for (int k = 0; k < n; k++) begin
            errs = 0;
            for (int c = 0; c < CPB; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (get_tx(i) !== exp_bits[k]) errs++;
            end
            check($sformatf("%s bit%0d (want %0d) wrong cycles", tag, k, exp_bits[k]), errs, 0);
        end
        @(negedge clk);
        check($sformatf("%s tx_done pulse", tag), get_done(i), 1);
    endtask

    // Counts idle-high samples (from the current one) until the next start bit.
    task automatic measure_gap(input int i, output int gap, output int busy_low);
        gap = 0;
        busy_low = 0;
        while (get_tx(i) === 1'b1 && gap < 50) begin
            if (get_busy(i) !== 1'b1) busy_low++;
            gap++;
            @(negedge clk);
        end
    endtask

    initial begin
        int d0, r0, gap, blow, viol;

        vecs[0] = '{0, 8'h5A, 1'b0, 1'b0, 1};
        vecs[1] = '{0, 8'h01, 1'b0, 1'b0, 1};
        vecs[2] = '{1, 8'h07, 1'b1, 1'b1, 2};
        vecs[3] = '{1, 8'hFF, 1'b1, 1'b0, 2};
        vecs[4] = '{1, 8'h10, 1'b1, 1'b1, 2};
        vecs[5] = '{2, 8'h07, 1'b1, 1'b0, 1};
        vecs[6] = '{2, 8'h00, 1'b1, 1'b1, 1};
        vecs[7] = '{2, 8'hFE, 1'b1, 1'b0, 1};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", tx0, 1);
        check("reset busy", busy0, 0);
        check("reset rd_en", rd_en0, 0);
        check("reset done", done0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte with exact request/start timing
        d0 = done_cnt0; r0 = rden_cnt0;
        push(0, 8'hA5);
        @(negedge clk);
        check("t1 rd_en cycle1", rd_en0, 1);
        check("t1 busy cycle1", busy0, 1);
        @(negedge clk);
        check("t1 rd_en cycle2", rd_en0, 0);
        check("t1 tx cycle2", tx0, 1);
        @(negedge clk);
        expect_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, "t1");
        repeat (3) @(negedge clk);
        check("t1 done count", done_cnt0 - d0, 1);
        check("t1 rd_en count", rden_cnt0 - r0, 1);
        check("t1 fifo empty", q0.size(), 0);
        check("t1 busy after", busy0, 0);

        // 2: three preloaded bytes back-to-back
        d0 = done_cnt0; r0 = rden_cnt0;
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
        expect_frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b0, "t2 f0");
        measure_gap(0, gap, blow);
        check("t2 gap01", gap, 2);
        expect_frame(0, 8'hFF, 1'b0, 1'b0, 1, 1'b1, "t2 f1");
        measure_gap(0, gap, blow);
        check("t2 gap12", gap, 2);
        expect_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, "t2 f2");
        repeat (3) @(negedge clk);
        check("t2 done count", done_cnt0 - d0, 3);
        check("t2 rd_en count", rden_cnt0 - r0, 3);

        // 3: table-driven frames across all three configurations
        foreach (vecs[v]) begin
            push(vecs[v].inst, vecs[v].data);
            expect_frame(vecs[v].inst, vecs[v].data, vecs[v].has_par, vecs[v].par,
                         vecs[v].nstop, 1'b0, $sformatf("vec%0d", v));
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d busy idle", v), get_busy(vecs[v].inst), 0);
        end

        // 4: reset during data bit 3 of 0x55 with 0x66 still queued
        d0 = done_cnt0; r0 = rden_cnt0;
        push(0, 8'h55); push(0, 8'h66);
        viol = 0;
        @(negedge clk);
        while (tx0 !== 1'b0 && viol < 50) begin @(negedge clk); viol++; end
        repeat (CPB + 3 * CPB + 1) @(negedge clk);
        check("t4 in bit3", tx0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t4 reset tx", tx0, 1);
        check("t4 reset busy", busy0, 0);
        rst_n = 1'b1;
        expect_frame(0, 8'h66, 1'b0, 1'b0, 1, 1'b0, "t4 next");
        repeat (3) @(negedge clk);
        check("t4 done count", done_cnt0 - d0, 1);
        check("t4 rd_en count", rden_cnt0 - r0, 2);
        check("t4 fifo empty", q0.size(), 0);

        // 5: empty FIFO held for 1000 cycles
        viol = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (rd_en0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) viol++;
            if (rd_en1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) viol++;
            if (rd_en2 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) viol++;
        end
        check("t5 idle violations", viol, 0);

        // 6: second byte written while the first is mid-frame
        d0 = done_cnt0; r0 = rden_cnt0;
        push(0, 8'h18);
        fork
            expect_frame(0, 8'h18, 1'b0, 1'b0, 1, 1'b0, "t6 f0");
            begin
                repeat (25) @(negedge clk);
                push(0, 8'h81);
            end
        join
        measure_gap(0, gap, blow);
        check("t6 gap", gap, 2);
        check("t6 busy low in gap", blow, 0);
        expect_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, "t6 f1");
        repeat (3) @(negedge clk);
        check("t6 done count", done_cnt0 - d0, 2);
        check("t6 rd_en count", rden_cnt0 - r0, 2);
        check("fifo underflows", underflow_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_fifo

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter that drains the synchronous FIFO and serialises each byte onto a single TX line.
- Sits directly downstream of synq_fifo and is its sole reader: it drives rd_en and consumes rd_data and f_empty.
- Frame format: 8N1 by default, with optional parity and 2 stop bits. Bits are sent LSB first.

Parameters:
- data_width, 8, payload bits per frame; must match the FIFO's data_width.
- clks_per_bit, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- parity_en, 0, 1 inserts a parity bit after the data bits.
- parity_odd, 0, 0 = even parity, 1 = odd parity; ignored when parity_en = 0.
- stop_bits, 1, number of stop bits; legal values are 1 and 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- f_empty  in  1  FIFO empty flag.
- rd_data  in  data_width  FIFO read data; valid only in the cycle after an rd_en cycle.
- rd_en  out  1  FIFO pop request; one-cycle pulse.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  high whenever state != IDLE.
- tx_done  out  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - Next cycle: state = IDLE, tx = 1, rd_en = 0, tx_busy = 0, tx_done = 0.
  - All counters cleared.
  - Reset mid-frame aborts the frame. The byte already popped is discarded, not re-read.
- States: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx = 1. If f_empty = 0, go to REQ; otherwise stay in IDLE.
- REQ: exactly 1 cycle; rd_en = 1, decoded from state, no other cycle asserts it. Go to LOAD.
- LOAD: exactly 1 cycle.
  - The FIFO's registered rd_data is valid in this cycle.
  - Capture it into the shift register, since the FIFO drives rd_data = 0 on non-read cycles.
  - Compute parity = XOR of the data bits XOR parity_odd.
  - Set tx = 0. Go to START.
- Bit timing: a baud counter counts 0 .. clks_per_bit-1. Each of START, DATA, PARITY and STOP holds tx constant for exactly clks_per_bit cycles per bit.
- START: tx = 0. Then go to DATA.
- DATA: tx = shift_reg[0]; shift right at each bit boundary. The bit counter runs 0 .. data_width-1. After the last bit, go to PARITY if parity_en = 1, otherwise go to STOP.
- PARITY: tx = computed parity bit for one bit time. Go to STOP.
- STOP: tx = 1 for stop_bits × clks_per_bit cycles. At the final cycle:
  - tx_done pulses in the following cycle.
  - If f_empty = 0, go to REQ (back-to-back); otherwise go to IDLE.
- Timing summary:
  - f_empty falls while in IDLE at cycle 0: rd_en is high in cycle 1, and the start bit begins in cycle 3.
  - Minimum inter-frame idle (tx = 1) gap beyond the stop bits: 2 cycles (REQ + LOAD).
- tx is a registered output with no combinational path from any input.
- FIFO protocol: rd_en is only asserted after f_empty = 0 was sampled. As the sole reader, the block can never pop an empty FIFO.
- Concurrent FIFO writes during a frame have no effect until the STOP/IDLE decision.
- Counter widths: baud counter is $clog2(clks_per_bit) bits; bit counter is $clog2(data_width)+1 bits; no wrap-around is relied on.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE .. STOP, 3 bits);
  - default clks_per_bit;
  - parity-mode constants.
  - The future uart_rx reuses it.
- One sub-module: uart_baud_gen (clks_per_bit parameter). Inputs: clk, rst_n, a synchronous clear. Output: a one-cycle bit_tick at count clks_per_bit-1. It is cleared on LOAD so the start bit is exactly full-width.

Test Plan (clks_per_bit = 4 unless stated):
1. Single byte: write 0xA5 into the FIFO. Expect:
   - rd_en high for 1 cycle;
   - then tx = 0 for 4 cycles, data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles;
   - tx_done pulses once and the FIFO ends empty.
2. Back-to-back: preload 0x00, 0xFF, 0x3C. Expect three frames, each separated by exactly 2 idle-high cycles after the stop bit, three tx_done pulses, and rd_en pulsed exactly 3 times.
3. Parity: parity_en = 1, parity_odd = 0, byte 0x07. Expect the parity bit = 1 after bit 7. Repeat with parity_odd = 1: parity bit = 0. With stop_bits = 2, expect the stop high for 8 cycles.
4. Reset mid-frame: assert rst_n = 0 during DATA bit 3 of 0x55 while the FIFO still holds 0x66. Expect:
   - tx = 1 and tx_busy = 0 at the next edge;
   - after release, the next frame transmits 0x66, not 0x55.
5. Empty FIFO: hold f_empty = 1 for 1000 cycles. Expect rd_en never asserted, tx constantly 1, tx_busy = 0.
6. Write during transmission: write 0x81 while 0x18 is mid-frame. Expect 0x81 to follow directly via STOP→REQ, with no IDLE cycle in between.
